// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller for the IF stage.
// A hit returns its instruction combinationally in the lookup cycle.
// A miss stalls the pipeline and refills the whole line, word 0 first, before the lookup is retried.
module icache_ctrl #(
    parameter int unsigned bit_size = 32,
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned LINES    = 16,
    parameter int unsigned WORDS    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic [ADDR_W-1:0]   core_addr,
    output logic [bit_size-1:0] core_rdata,
    output logic                IC_stall,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [bit_size-1:0] mem_rdata,
    input  logic                mem_ready,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
);

    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int unsigned SLOT_W = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);
    localparam logic [15:0]      CNT_MAX   = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Storage arrays: tags and data carry no reset, only the valid bits do
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [bit_size-1:0] data_arr [LINES*WORDS];
    logic [LINES-1:0]    valid_q;

    // Refill context latched at miss detection
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic [OFF_W-1:0] cnt_q;

    // Fetch address fields
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_word;
    logic [SLOT_W-1:0] req_slot;
    logic [SLOT_W-1:0] fill_slot;
    logic              unused_byte_off;

    logic lookup_hit;
    logic miss_start;
    logic fill_wr;
    logic fill_last;

    assign req_tag         = core_addr[ADDR_W-1 -: TAG_W];
    assign req_idx         = core_addr[2+OFF_W +: IDX_W];
    assign req_word        = core_addr[2 +: OFF_W];
    assign req_slot        = {req_idx, req_word};
    assign fill_slot       = {idx_q, cnt_q};
    assign unused_byte_off = ^core_addr[1:0];

    // Combinational tag compare, only meaningful while idle
    assign lookup_hit = (state_q == IDLE) && core_req && valid_q[req_idx] &&
                        (tag_arr[req_idx] == req_tag);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and core/memory-facing outputs
    always_comb begin
        state_d    = state_q;
        core_rdata = '0;
        IC_stall   = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        miss_start = 1'b0;
        fill_wr    = 1'b0;
        fill_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    if (lookup_hit) begin
                        core_rdata = data_arr[req_slot];
                    end else begin
                        IC_stall   = 1'b1;
                        miss_start = 1'b1;
                        state_d    = REFILL;
                    end
                end
            end
            REFILL: begin
                IC_stall = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag_q, idx_q, cnt_q, 2'b00};
                if (mem_ready) begin
                    fill_wr = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        fill_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Refill context, valid bits and saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= '0;
            tag_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (miss_start) begin
                tag_q <= req_tag;
                idx_q <= req_idx;
                cnt_q <= '0;
                if (miss_cnt != CNT_MAX) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
            if (fill_wr) begin
                cnt_q <= cnt_q + OFF_W'(1);
            end
            if (fill_last) begin
                valid_q[idx_q] <= 1'b1;
            end
            if (lookup_hit && (hit_cnt != CNT_MAX)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
        end
    end

    // Line fill writes; a write coinciding with reset is dropped with the refill
    always_ff @(posedge clk) begin
        if (rst && fill_wr) begin
            data_arr[fill_slot] <= mem_rdata;
            if (fill_last) begin
                tag_arr[idx_q] <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: a reference cache model predicts the hits, misses, counters and refill addresses.
// A memory responder serves the refills, and a monitor checks every instruction the DUT delivers.
module tb_icache_ctrl;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic [17:0] core_addr;
    logic [31:0] core_rdata;
    logic        IC_stall;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Instruction memory image and expectation queues
    logic [31:0] mem_img [65536];
    logic [31:0] exp_q[$];
    logic [17:0] mem_exp_q[$];

    // Reference cache model: which tag each line holds
    bit          m_valid [16];
    logic [9:0]  m_tag   [16];
    int          m_hit;
    int          m_miss;

    int mem_wait     = 2;
    bit rand_lat     = 0;
    bit inject_ready = 0;
    int rdy_seen     = 0;

    icache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_rdata (core_rdata),
        .IC_stall   (IC_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: every delivered instruction is checked against the oldest expectation
    always @(negedge clk) begin
        if (rst && core_req && !IC_stall) begin
            if (exp_q.size() == 0) fail_now("unexpected_fetch_delivery");
            else chk("core_rdata", core_rdata, exp_q.pop_front());
        end
    end

    // Memory responder: answers mem_req after a configurable number of wait cycles
    initial begin
        int wait_left;
        mem_ready = 1'b0;
        mem_rdata = '0;
        wait_left = mem_wait;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (inject_ready) begin
                mem_ready    = 1'b1;
                mem_rdata    = $urandom;
                inject_ready = 0;
            end else if (mem_req) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_img[mem_addr[17:2]];
                    rdy_seen++;
                    if (mem_exp_q.size() == 0) fail_now("unexpected_refill_read");
                    else chk("refill_addr", 32'(mem_addr), 32'(mem_exp_q.pop_front()));
                    wait_left = rand_lat ? int'($urandom_range(0, 3)) : mem_wait;
                end else begin
                    wait_left--;
                end
            end else begin
                wait_left = rand_lat ? int'($urandom_range(0, 3)) : mem_wait;
            end
        end
    end

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    // Issue one fetch and hold it until delivered; cyc = cycles from lookup to delivery inclusive
    task automatic fetch(input logic [17:0] a, output int cyc);
        logic [9:0] tg;
        logic [3:0] ix;
        bit         miss;
        tg   = a[17:8];
        ix   = a[7:4];
        miss = !(m_valid[ix] && (m_tag[ix] == tg));
        if (miss) begin
            for (int k = 0; k < 4; k++) mem_exp_q.push_back({tg, ix, 2'(k), 2'b00});
            m_valid[ix] = 1;
            m_tag[ix]   = tg;
            if (m_miss < 65535) m_miss++;
        end
        if (m_hit < 65535) m_hit++;
        exp_q.push_back(mem_img[a[17:2]]);
        core_addr = a;
        core_req  = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("lookup_stall", 32'(IC_stall), 32'(miss));
            if (miss && cyc == 2) begin
                chk("mem_req_in_refill", 32'(mem_req), 32'd1);
                chk("miss_cnt_after_detect", 32'(miss_cnt), 32'(m_miss));
            end
            if (!IC_stall) break;
            if (cyc >= 200) begin
                fail_now("fetch_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("hit_cnt", 32'(hit_cnt), 32'(m_hit));
        chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    endtask

    // Idle cycles with no fetch; optionally a stray mem_ready that must be ignored
    task automatic idle(input int n, input bit inj);
        core_req = 1'b0;
        if (inj) inject_ready = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_stall", 32'(IC_stall), 32'd0);
            chk("idle_rdata", core_rdata, 32'd0);
            chk("idle_mem_req", 32'(mem_req), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("idle_hit_cnt", 32'(hit_cnt), 32'(m_hit));
        chk("idle_miss_cnt", 32'(miss_cnt), 32'(m_miss));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [17:0] ra;
        rst       = 1'b0;
        core_req  = 1'b0;
        core_addr = '0;
        for (int i = 0; i < 65536; i++) mem_img[i] = $urandom;
        for (int k = 0; k < 4; k++) mem_img[16'h0040 + k] = 32'hA0 + 32'(k);
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(IC_stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Cold miss with 2 wait cycles per word: 1 + 12 + 1 cycles to delivery
        fetch(18'h00104, cyc);
        chk("miss_penalty", 32'(cyc), 32'd14);
        chk("first_miss_cnt", 32'(miss_cnt), 32'd1);

        // Back-to-back hits in the freshly filled line
        fetch(18'h00100, cyc);
        chk("hit_latency_0", 32'(cyc), 32'd1);
        fetch(18'h00108, cyc);
        chk("hit_latency_2", 32'(cyc), 32'd1);
        fetch(18'h0010C, cyc);
        chk("hit_latency_3", 32'(cyc), 32'd1);
        chk("hit_cnt_after_hits", 32'(hit_cnt), 32'd4);

        // Conflict on index 0 evicts the earlier line
        fetch(18'h00504, cyc);
        chk("conflict_penalty", 32'(cyc), 32'd14);
        fetch(18'h00104, cyc);
        chk("evicted_refetch_miss", 32'(miss_cnt), 32'd3);

        // Reset in the middle of a refill after two words
        idle(2, 1'b0);
        rdy_seen  = 0;
        core_addr = 18'h00204;
        core_req  = 1'b1;
        for (int k = 0; k < 4; k++) mem_exp_q.push_back(18'h00200 + 18'(4 * k));
        for (int i = 0; i < 100 && rdy_seen < 2; i++) @(posedge clk);
        #1;
        if (rdy_seen < 2) fail_now("refill_progress_timeout");
        rst      = 1'b0;
        core_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_exp_q.delete();
        model_reset();
        @(negedge clk);
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_stall", 32'(IC_stall), 32'd0);
        chk("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        #1;
        idle(3, 1'b1);
        fetch(18'h00204, cyc);
        chk("post_reset_miss_cnt", 32'(miss_cnt), 32'd1);

        // Randomized fetch mix with variable memory latency and stray mem_ready pulses
        rand_lat = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(int'($urandom_range(1, 3)), $urandom_range(0, 1) == 1);
            end else begin
                ra = {10'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                fetch(ra, cyc);
            end
        end

        // Hit counter saturation
        fetch(18'h00204, cyc);
        for (int n = 0; n < 65540; n++) fetch(18'h00204, cyc);
        chk("hit_cnt_saturated", 32'(hit_cnt), 32'h0000FFFF);
        fetch(18'h00208, cyc);
        chk("hit_cnt_stays_saturated", 32'(hit_cnt), 32'h0000FFFF);

        idle(2, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("refill_queue_drained", 32'(mem_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache controller in the IF stage.
- Serves instruction fetches from the PC and refills lines from instruction memory.
- Raises IC_stall to the hazard detection unit while a miss is being serviced; that unit freezes every pipeline register for the duration.
- Includes saturating hit/miss performance counters.

Parameters:
- bit_size, 32, data word width.
- ADDR_W, 18, byte address width of core_addr and mem_addr.
- LINES, 16, number of cache lines (power of 2).
- WORDS, 4, words per line (power of 2).
- Address split:
  - bits [1:0]: byte offset, ignored.
  - next log2(WORDS) bits: word offset.
  - next log2(LINES) bits: index.
  - remaining bits: tag.
  - With defaults, tag = core_addr[17:8], index = [7:4], word offset = [3:2].

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active low.
- core_req  input  1  fetch request this cycle.
- core_addr  input  ADDR_W  fetch byte address (PC).
- core_rdata  output  bit_size  fetched instruction.
- IC_stall  output  1  miss in progress; goes to the hazard detection unit.
- mem_req  output  1  word read request to instruction memory.
- mem_addr  output  ADDR_W  word-aligned refill address.
- mem_rdata  input  bit_size  memory read data.
- mem_ready  input  1  one-cycle pulse: mem_rdata is valid for the current mem_addr.
- hit_cnt  output  16  saturating count of hits.
- miss_cnt  output  16  saturating count of misses.

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE; all valid bits cleared; word counter=0; hit_cnt=miss_cnt=0.
  - mem_req=0; mem_addr=0; IC_stall=0; core_rdata=0.
  - Tag and data arrays are not reset.
  - Reset mid-refill abandons the refill. The partial line stays invalid. A mem_ready arriving after reset is ignored.
- States: IDLE, REFILL.
- IDLE:
  - Lookup is combinational: hit = core_req & valid[index] & (tag_array[index]==tag).
  - On hit: core_rdata = data[index][word] in the same cycle; IC_stall=0; hit_cnt increments at the edge.
  - On core_req & !hit:
    - IC_stall=1 combinationally; core_rdata=0.
    - At the edge: latch tag and index; word counter=0; go to REFILL; miss_cnt increments.
  - When core_req==0: IC_stall=0, core_rdata=0, no counter change.
- REFILL:
  - IC_stall=1 and mem_req=1 every cycle.
  - mem_addr = {latched tag, latched index, counter, 2'b00}; word 0 is fetched first (no critical-word-first).
  - On mem_ready: write mem_rdata to data[index][counter]; counter += 1.
  - On the mem_ready of word WORDS-1: write tag_array[index], set valid[index], go to IDLE. IC_stall is still 1 in that cycle.
  - mem_ready==0: hold the current address and counter indefinitely.
- After refill, IDLE re-evaluates the current core_addr. The pipeline is frozen, so this is normally the same PC and it hits one cycle after the last mem_ready.
- Miss penalty: 1 (miss-detect cycle) + sum of the WORDS memory latencies + 1 (re-lookup cycle).
- A refill overwrites the line unconditionally. There is no write-back, since the cache is read-only.
- Changes to core_addr or core_req during REFILL do not affect the refill in progress.
- mem_ready while in IDLE is ignored.
- Counters saturate at 16'hFFFF and never wrap.

Test Plan:
1. Reset, then core_req=1, core_addr=18'h00104 → IC_stall=1 in the same cycle; next cycle mem_req=1, mem_addr=18'h00100; miss_cnt=1.
2. Memory answers 4 words 0xA0..0xA3, each after 2 wait cycles → mem_addr steps 0x100, 0x104, 0x108, 0x10C. After the 4th mem_ready, IC_stall=0 and core_rdata=0xA1 for addr 0x104. Stall length = 1 + 12 + 1 cycles.
3. Fetch 0x100, 0x108, 0x10C back-to-back → 3 hits with no stall; core_rdata=0xA0, 0xA2, 0xA3; hit_cnt=4, counting the re-lookup hit.
4. Conflict: fetch 18'h00504 (same index 0, tag 0x005) → miss and refill; a subsequent fetch of 0x104 misses again (line evicted); miss_cnt=3.
5. rst=0 for one cycle in the middle of a refill, after 2 of 4 words → mem_req=0, IC_stall=0, counters 0. A late mem_ready is ignored. The next fetch of the same address misses.
6. Force hit_cnt to 16'hFFFF, then perform another hit → hit_cnt stays 16'hFFFF.
